// File: rtl/freq_offset_detector.sv
// -----------------------------------------------------------------------------
// freq_offset_detector
//
// Carrier-loop false-lock / high-frequency-offset detector.  The loop's
// frequency error is rectified, scaled and passed through a leaky integrator.
// If the filtered level stays above a programmable threshold for DWELL
// consecutive locked samples, the block declares a high frequency offset
// and requests a single sweep restart from the carrier loop.  The declaration
// is released with 2:1 hysteresis, or at once when lock is lost.
//
// Sample strobe: clkEn is a one-clk-wide qualifier.  freqError and demodLock
// are only looked at on cycles where clkEn is high.  Neither the integrator
// nor the FSM changes on any other cycle.  clkEn may stay high continuously,
// which gives one sample per clk.  There is no back-pressure.
//
// Parameters:
//   DWELL              consecutive qualifying samples needed to declare (1..4095)
//
// Ports:
//   clk                system clock
//   reset              synchronous, active-high reset
//   clkEn              sample strobe
//   freqError[11:0]    signed loop frequency error, valid with clkEn
//   demodLock          carrier-loop lock indication
//   falseLockAlpha     unsigned Q0.16 filter gain (bus domain, quasi-static)
//   falseLockThreshold unsigned detection threshold (bus domain, quasi-static)
//   offsetLevel[15:0]  filtered error magnitude (acc[31:16])
//   highFreqOffset     offset declared (status bit)
//   sweepRestart       one-clk pulse requesting carrier reacquisition
//   dbgState[1:0]      FSM state for observation: 0 CLEAR, 1 PENDING, 2 OFFSET
// -----------------------------------------------------------------------------
module freq_offset_detector #(
  parameter int DWELL = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clkEn,
  input  logic [11:0] freqError,
  input  logic        demodLock,
  input  logic [15:0] falseLockAlpha,
  input  logic [15:0] falseLockThreshold,
  output logic [15:0] offsetLevel,
  output logic        highFreqOffset,
  output logic        sweepRestart,
  output logic [1:0]  dbgState
);

  localparam logic [11:0] DWELL_C = 12'(DWELL);

  typedef enum logic [1:0] {
    S_CLEAR   = 2'd0,
    S_PENDING = 2'd1,
    S_OFFSET  = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Config capture.  Both words come from the processor bus domain.  Two flops
  // each keep metastability out of the datapath.  A word caught mid-write may
  // be used mixed for one sample, which is harmless for a slow status filter.
  // ---------------------------------------------------------------------------
  logic [15:0] alpha_meta_q, alpha_q;
  logic [15:0] thr_meta_q, thr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      alpha_meta_q <= '0;
      alpha_q      <= '0;
      thr_meta_q   <= '0;
      thr_q        <= '0;
    end else begin
      alpha_meta_q <= falseLockAlpha;
      alpha_q      <= alpha_meta_q;
      thr_meta_q   <= falseLockThreshold;
      thr_q        <= thr_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Magnitude: |freqError| << 4.  -2048 has no positive 12-bit counterpart,
  // so it is clamped to 2047 before the shift.
  // ---------------------------------------------------------------------------
  logic [11:0] neg_err;
  logic [10:0] mag11;
  logic [15:0] mag;

  always_comb begin
    neg_err = (~freqError) + 12'd1;
    mag11   = freqError[10:0];
    if (freqError[11]) begin
      if (freqError == 12'h800) begin
        mag11 = 11'h7FF;
      end else begin
        mag11 = neg_err[10:0];
      end
    end
    mag = {1'b0, mag11, 4'b0000};
  end

  // ---------------------------------------------------------------------------
  // Leaky integrator: acc += (mag - level) * alpha, saturated to 32 bits.
  // The product spans roughly +/-2^32, so the sum is formed in 35 bits.  Going
  // below zero clamps to 0, and going above 2^32-1 clamps to all ones.
  // ---------------------------------------------------------------------------
  logic [31:0]        acc_q, acc_d;
  logic signed [16:0] diff;
  logic signed [33:0] prod;
  logic signed [34:0] sum;

  always_comb begin
    diff  = $signed({1'b0, mag}) - $signed({1'b0, acc_q[31:16]});
    prod  = diff * $signed({1'b0, alpha_q});
    sum   = $signed({3'b000, acc_q}) + $signed({prod[33], prod});
    acc_d = acc_q;
    if (clkEn) begin
      if (sum[34]) begin
        acc_d = '0;
      end else if (sum[33:32] != 2'b00) begin
        acc_d = '1;
      end else begin
        acc_d = sum[31:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign offsetLevel = acc_q[31:16];

  // ---------------------------------------------------------------------------
  // Detection FSM.  All decisions use the registered level, so a sample's
  // qualification reflects the filter state before that sample's own update.
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [11:0] cnt_inc;
  logic [15:0] thr_half;
  logic        qualify;
  logic        release_c;

  assign cnt_inc  = cnt_q + 12'd1;
  assign thr_half = {1'b0, thr_q[15:1]};
  // A strict compare means threshold 0xFFFF can never qualify.
  assign qualify   = clkEn & demodLock & (offsetLevel > thr_q);
  assign release_c = ~demodLock | (offsetLevel < thr_half);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clkEn) begin
      case (state_q)
        S_CLEAR: begin
          if (qualify) begin
            if (DWELL_C == 12'd1) begin
              state_d = S_OFFSET;
              cnt_d   = '0;
            end else begin
              state_d = S_PENDING;
              cnt_d   = 12'd1;
            end
          end
        end
        S_PENDING: begin
          if (qualify) begin
            if (cnt_inc == DWELL_C) begin
              state_d = S_OFFSET;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = S_CLEAR;
            cnt_d   = '0;
          end
        end
        S_OFFSET: begin
          // Release always wins.  Even a sample that would qualify again
          // lands in CLEAR, and the dwell then restarts from zero.
          if (release_c) begin
            state_d = S_CLEAR;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs are registered from the state register, so they move one clk
  // after the state changes.  The restart pulse fires on the first cycle the
  // status bit is set.
  // ---------------------------------------------------------------------------
  logic hfo_q;
  logic sweep_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hfo_q   <= 1'b0;
      sweep_q <= 1'b0;
    end else begin
      hfo_q   <= (state_q == S_OFFSET);
      sweep_q <= (state_q == S_OFFSET) & ~hfo_q;
    end
  end

  assign highFreqOffset = hfo_q;
  assign sweepRestart   = sweep_q;
  assign dbgState       = state_q;

endmodule
